// File: rtl/acc_feeder.sv
// acc_feeder: groups a signed add/sub operand stream into s_last-terminated windows,
// drives an external accumulator (acc_init/acc_sign/acc_in) and captures each window
// total into a held result register.
// Ports: s_valid/s_ready/s_data/s_sub/s_last = operand stream;
//        acc_init/acc_sign/acc_in -> accumulator, acc_out <- accumulator;
//        r_valid/r_ready/r_data/r_count = result stream.
// Optional macro ACC_FEEDER_OVF_EN adds r_ovf, a per-window signed overflow flag.
module acc_feeder #(
    parameter int bit_width = 16,
    parameter int cnt_width = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [bit_width-1:0] s_data,
    input  logic                 s_sub,
    input  logic                 s_last,
    output logic                 acc_init,
    output logic                 acc_sign,
    output logic [bit_width-1:0] acc_in,
    input  logic [bit_width-1:0] acc_out,
    output logic                 r_valid,
    input  logic                 r_ready,
    output logic [bit_width-1:0] r_data,
`ifdef ACC_FEEDER_OVF_EN
    output logic                 r_ovf,
`endif
    output logic [cnt_width-1:0] r_count
);
    typedef enum logic [1:0] {IDLE, ACCUM, CAPTURE} state_t;
    state_t               state_q, state_d;
    logic [cnt_width-1:0] cnt_q, cnt_d, r_count_q, r_count_d;
    logic [bit_width-1:0] r_data_q, r_data_d;
    logic                 r_valid_q, r_valid_d;
    logic                 fire, first, capture;
    always_comb begin
        s_ready   = state_q != CAPTURE;
        fire      = s_valid & s_ready;
        first     = state_q == IDLE;
        capture   = state_q == CAPTURE && (!r_valid_q || r_ready);
        // first operand loads the full negation; later subtracts use ~x with carry-in
        acc_init  = fire & first;
        acc_sign  = fire & !first & s_sub;
        acc_in    = !fire ? '0 : !s_sub ? s_data : first ? ~s_data + bit_width'(1) : ~s_data;
        state_d   = capture ? IDLE : (fire & s_last) ? CAPTURE : fire ? ACCUM : state_q;
        cnt_d     = capture ? '0 : !fire ? cnt_q : first ? cnt_width'(1) :
                    (&cnt_q) ? cnt_q : cnt_q + cnt_width'(1);
        r_valid_d = capture | (r_valid_q & !r_ready);
        r_data_d  = capture ? acc_out : r_data_q;
        r_count_d = capture ? cnt_q : r_count_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            r_count_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            r_valid_q <= r_valid_d;
            r_data_q  <= r_data_d;
            r_count_q <= r_count_d;
        end
    end
    assign r_valid = r_valid_q;
    assign r_data  = r_data_q;
    assign r_count = r_count_q;
`ifdef ACC_FEEDER_OVF_EN
    logic [bit_width:0] ext_a, ext_d, sum_x;
    logic               ovf_q, ovf_d, r_ovf_q, r_ovf_d;
    always_comb begin
        ext_a   = {acc_out[bit_width-1], acc_out};
        ext_d   = {s_data[bit_width-1], s_data};
        sum_x   = s_sub ? ext_a - ext_d : ext_a + ext_d;
        // negating the most negative value as a first operand is the only first-op overflow
        ovf_d   = capture ? 1'b0 : !fire ? ovf_q :
                  first ? (s_sub && s_data == {1'b1, {(bit_width-1){1'b0}}}) :
                  ovf_q | (sum_x[bit_width] ^ sum_x[bit_width-1]);
        r_ovf_d = capture ? ovf_q : r_ovf_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q   <= 1'b0;
            r_ovf_q <= 1'b0;
        end else begin
            ovf_q   <= ovf_d;
            r_ovf_q <= r_ovf_d;
        end
    end
    assign r_ovf = r_ovf_q;
`endif
endmodule

// File: tb/tb_acc_feeder.sv
// tb_acc_feeder: directed + model-checked bench for acc_feeder with a behavioural accumulator.
module tb_acc_feeder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid, s_ready, s_sub, s_last;
    logic [15:0] s_data;
    logic        acc_init, acc_sign;
    logic [15:0] acc_in, acc_out;
    logic        r_valid, r_ready;
    logic [15:0] r_data;
    logic [7:0]  r_count;
`ifdef ACC_FEEDER_OVF_EN
    logic        r_ovf;
`endif
    int tests = 0;
    int fails = 0;
    logic rand_ready = 1'b0;

    acc_feeder #(.bit_width(16), .cnt_width(8)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sub(s_sub), .s_last(s_last),
        .acc_init(acc_init), .acc_sign(acc_sign), .acc_in(acc_in), .acc_out(acc_out),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
`ifdef ACC_FEEDER_OVF_EN
        .r_ovf(r_ovf),
`endif
        .r_count(r_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) acc_out <= '0;
        else if (acc_init) acc_out <= acc_in + {15'b0, acc_sign};
        else acc_out <= acc_out + acc_in + {15'b0, acc_sign};
    end

    typedef struct {
        logic [15:0] d;
        logic [7:0]  c;
        logic        o;
    } res_t;
    res_t        exp_q[$];
    res_t        r;
    logic [15:0] m_sum = '0;
    int          m_cnt = 0;
    logic        m_in_win = 1'b0;
    logic        m_ovf = 1'b0;
    logic        chk_acc = 1'b0;
    logic        prev_hold = 1'b0;
    logic [15:0] prev_data;
    logic [7:0]  prev_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        int ex;
        int d;
        if (rst) begin
            exp_q.delete();
            m_in_win = 1'b0;
            chk_acc = 1'b0;
            prev_hold = 1'b0;
            return;
        end
        if (chk_acc) check("acc_total", {16'b0, acc_out}, {16'b0, m_sum});
        chk_acc = 1'b0;
        if (prev_hold) begin
            check("hold_valid", {31'b0, r_valid}, 32'd1);
            check("hold_data", {16'b0, r_data}, {16'b0, prev_data});
            check("hold_count", {24'b0, r_count}, {24'b0, prev_cnt});
        end
        prev_hold = r_valid & !r_ready;
        prev_data = r_data;
        prev_cnt = r_count;
        if (s_valid & s_ready) begin
            d = int'($signed(s_data));
            if (!m_in_win) begin
                ex = s_sub ? -d : d;
                m_cnt = 1;
                m_ovf = s_sub && s_data == 16'h8000;
            end else begin
                ex = int'($signed(m_sum)) + (s_sub ? -d : d);
                if (ex > 32767 || ex < -32768) m_ovf = 1'b1;
                m_cnt = m_cnt < 255 ? m_cnt + 1 : 255;
            end
            m_sum = ex[15:0];
            chk_acc = 1'b1;
            if (s_last) exp_q.push_back('{m_sum, m_cnt[7:0], m_ovf});
            m_in_win = !s_last;
        end else begin
            check("acc_hold", {14'b0, acc_init, acc_sign, acc_in}, 32'd0);
        end
        if (r_valid & r_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_result", {31'b0, r_valid}, 32'd0);
            end else begin
                r = exp_q.pop_front();
                check("res_data", {16'b0, r_data}, {16'b0, r.d});
                check("res_count", {24'b0, r_count}, {24'b0, r.c});
`ifdef ACC_FEEDER_OVF_EN
                check("res_ovf", {31'b0, r_ovf}, {31'b0, r.o});
`endif
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
        if (rand_ready) r_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic put(input logic [15:0] d, input logic sub, input logic last);
        s_valid = 1'b1; s_data = d; s_sub = sub; s_last = last;
    endtask

    task automatic idle_in();
        s_valid = 1'b0; s_data = '0; s_sub = 1'b0; s_last = 1'b0;
    endtask

    task automatic send(input logic [15:0] d, input logic sub, input logic last);
        int n = 0;
        put(d, sub, last);
        #1;
        while (!s_ready && n < 50) begin
            cycle();
            n++;
        end
        check("s_ready_wait", {31'b0, s_ready}, 32'd1);
        cycle();
        idle_in();
    endtask

    initial begin
        idle_in();
        r_ready = 1'b1;
        cycle();
        cycle();
        check("rst_r_valid", {31'b0, r_valid}, 32'd0);
        check("rst_r_data", {16'b0, r_data}, 32'd0);
        check("rst_r_count", {24'b0, r_count}, 32'd0);
        check("rst_s_ready", {31'b0, s_ready}, 32'd1);
        rst = 1'b0;
        cycle();
        // 3 + 5 + 7
        put(16'd3, 1'b0, 1'b0); #1;
        check("t1_init0", {31'b0, acc_init}, 32'd1);
        check("t1_in0", {16'b0, acc_in}, 32'd3);
        cycle();
        put(16'd5, 1'b0, 1'b0); #1;
        check("t1_init1", {31'b0, acc_init}, 32'd0);
        cycle();
        put(16'd7, 1'b0, 1'b1); #1;
        cycle();
        idle_in(); #1;
        check("t1_capture_valid", {31'b0, r_valid}, 32'd0);
        check("t1_capture_ready", {31'b0, s_ready}, 32'd0);
        cycle();
        check("t1_valid", {31'b0, r_valid}, 32'd1);
        check("t1_data", {16'b0, r_data}, 32'h000F);
        check("t1_count", {24'b0, r_count}, 32'd3);
        cycle();
        check("t1_drop", {31'b0, r_valid}, 32'd0);
        // -4 + 10
        put(16'd4, 1'b1, 1'b0); #1;
        check("t2_in0", {16'b0, acc_in}, 32'hFFFC);
        check("t2_sign0", {31'b0, acc_sign}, 32'd0);
        cycle();
        put(16'd10, 1'b0, 1'b1);
        cycle();
        idle_in();
        cycle();
        check("t2_data", {16'b0, r_data}, 32'h0006);
        check("t2_count", {24'b0, r_count}, 32'd2);
        // 10 - 3 exercises the carry-in path
        put(16'd10, 1'b0, 1'b0);
        cycle();
        put(16'd3, 1'b1, 1'b1); #1;
        check("t2b_in", {16'b0, acc_in}, 32'hFFFC);
        check("t2b_sign", {31'b0, acc_sign}, 32'd1);
        cycle();
        idle_in();
        cycle();
        check("t2b_data", {16'b0, r_data}, 32'h0007);
        // -0x8000 single operand
        put(16'h8000, 1'b1, 1'b1);
        cycle();
        idle_in();
        cycle();
        check("t3_data", {16'b0, r_data}, 32'h8000);
        check("t3_count", {24'b0, r_count}, 32'd1);
`ifdef ACC_FEEDER_OVF_EN
        check("t3_ovf", {31'b0, r_ovf}, 32'd1);
`endif
        cycle();
        // back-pressure: {1,2} held, {5} stalls in CAPTURE
        r_ready = 1'b0;
        put(16'd1, 1'b0, 1'b0);
        cycle();
        put(16'd2, 1'b0, 1'b1);
        cycle();
        idle_in();
        cycle();
        check("t4_valid", {31'b0, r_valid}, 32'd1);
        check("t4_data", {16'b0, r_data}, 32'h0003);
        put(16'd5, 1'b0, 1'b1); #1;
        check("t4_ready_idle", {31'b0, s_ready}, 32'd1);
        cycle();
        idle_in();
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("t4_stall_ready", {31'b0, s_ready}, 32'd0);
            check("t4_stall_data", {16'b0, r_data}, 32'h0003);
            check("t4_stall_acc", {16'b0, acc_out}, 32'h0005);
        end
        r_ready = 1'b1;
        cycle();
        check("t4_second_valid", {31'b0, r_valid}, 32'd1);
        check("t4_second_data", {16'b0, r_data}, 32'h0005);
        check("t4_second_count", {24'b0, r_count}, 32'd1);
        cycle();
        check("t4_empty", {31'b0, r_valid}, 32'd0);
        // reset mid-window with a held result
        r_ready = 1'b0;
        send(16'd4, 1'b0, 1'b1);
        cycle();
        put(16'd1, 1'b0, 1'b0);
        cycle();
        put(16'd2, 1'b0, 1'b0);
        cycle();
        idle_in();
        rst = 1'b1; #1;
        check("t5_valid", {31'b0, r_valid}, 32'd0);
        check("t5_data", {16'b0, r_data}, 32'd0);
        check("t5_ready", {31'b0, s_ready}, 32'd1);
        cycle();
        rst = 1'b0;
        r_ready = 1'b1;
        put(16'd9, 1'b0, 1'b1);
        cycle();
        idle_in();
        cycle();
        check("t5_new_data", {16'b0, r_data}, 32'h0009);
        check("t5_new_count", {24'b0, r_count}, 32'd1);
        cycle();
`ifdef ACC_FEEDER_OVF_EN
        put(16'h7FFF, 1'b0, 1'b0);
        cycle();
        put(16'd1, 1'b0, 1'b1);
        cycle();
        idle_in();
        cycle();
        check("t6_data", {16'b0, r_data}, 32'h8000);
        check("t6_ovf", {31'b0, r_ovf}, 32'd1);
        send(16'd1, 1'b0, 1'b1);
        cycle();
        check("t6_clear", {31'b0, r_ovf}, 32'd0);
`endif
        // counter saturation: 300 ones
        for (int i = 0; i < 300; i++) send(16'd1, 1'b0, i == 299);
        cycle();
        check("sat_count", {24'b0, r_count}, 32'd255);
        check("sat_data", {16'b0, r_data}, 32'h012C);
        // mixed windows under random back-pressure
        rand_ready = 1'b1;
        for (int w = 0; w < 15; w++) begin
            int len = $urandom_range(1, 4);
            for (int k = 0; k < len; k++) send(16'($urandom), 1'($urandom_range(0, 1)), k == len - 1);
        end
        rand_ready = 1'b0;
        r_ready = 1'b1;
        repeat (6) cycle();
        check("drain", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/acc_feeder.md
Name: acc_feeder

Overview:
- Upstream sequencer for the `accumulator` block. It takes a valid/ready stream of signed operands, each tagged add/subtract, and groups them into windows terminated by `s_last`.
- It drives the accumulator's `init`/`sign`/`in` so that each window starts fresh.
- It captures the window total from the accumulator output into a held result register with its own valid/ready handshake.
- The accumulator register updates on every clock, so the feeder must drive "hold" values (`init`=0, `sign`=0, `in`=0) whenever no operand is issued.

Parameters:
- `bit_width`, 16, data width of operands, accumulator and result.
- `cnt_width`, 8, width of the per-window sample counter.

Ports:
- `clk`, input, 1, clock; rising edge.
- `rst`, input, 1, reset; asynchronous, active-high. The same signal resets the accumulator.
- `s_valid`, input, 1, operand valid.
- `s_ready`, output, 1, feeder accepts operand.
- `s_data`, input, `bit_width`, signed operand.
- `s_sub`, input, 1, 1 = subtract operand, 0 = add.
- `s_last`, input, 1, operand closes the current window.
- `acc_init`, output, 1, to accumulator `init`.
- `acc_sign`, output, 1, to accumulator `sign` (carry-in).
- `acc_in`, output, `bit_width`, to accumulator `in`.
- `acc_out`, input, `bit_width`, from accumulator `out`.
- `r_valid`, output, 1, result valid.
- `r_ready`, input, 1, consumer takes result.
- `r_data`, output, `bit_width`, window total.
- `r_count`, output, `cnt_width`, number of operands in the window.

Behaviour:
- fire = `s_valid` & `s_ready`.
- FSM states:
  - IDLE: awaiting first operand of a window.
  - ACCUM: window open.
  - CAPTURE: total being captured.
- Reset values: state = IDLE; `r_valid`=0; `r_data`=0; `r_count`=0; internal counter = 0; `ovf` = 0.
- `s_ready` = 1 in IDLE and ACCUM; 0 in CAPTURE.
- Accumulator drive is combinational from the current cycle:
  - no fire: `acc_init`=0, `acc_sign`=0, `acc_in`=0 (accumulator holds its value).
  - fire in IDLE (first operand): `acc_init`=1, `acc_sign`=0. `acc_in` = `s_data` for add, or (~`s_data`+1) mod 2^`bit_width` for subtract.
  - fire in ACCUM: `acc_init`=0. For add, `acc_in` = `s_data` and `acc_sign`=0. For subtract, `acc_in` = ~`s_data` and `acc_sign`=1.
- Transitions:
  - IDLE --fire & !`s_last`--> ACCUM.
  - IDLE --fire & `s_last`--> CAPTURE.
  - ACCUM --fire & `s_last`--> CAPTURE.
  - CAPTURE --result slot free--> IDLE. Result slot free = `r_valid`=0, or `r_valid` & `r_ready` in the same cycle.
  - CAPTURE with slot not free: stay in CAPTURE. Accumulator holds; `s_ready`=0.
- Capture timing:
  - The last operand fires at edge N.
  - `acc_out` holds the window total from edge N.
  - On the CAPTURE exit edge (N+1 at earliest): `r_data` <= `acc_out`, `r_count` <= counter, `r_valid` <= 1, counter <= 0.
  - Minimum latency from last-operand edge to `r_valid`=1 is 1 cycle.
- Counter: set to 1 on first fire; incremented on each later fire; saturates at 2^`cnt_width`-1.
- `r_valid` falls on `r_valid` & `r_ready` unless a capture occurs on the same edge, in which case it stays 1 with new data.
- `r_data`/`r_count` are stable while `r_valid` & !`r_ready`.
- Arithmetic is two's complement modulo 2^`bit_width`. Wrap is silent unless the optional feature below is compiled in.
- Minimum throughput: one window per (operands + 1) cycles. A 1-operand window takes 2 cycles.
- Reset mid-window or mid-CAPTURE discards the partial window and any held result. The next fire is treated as a first operand.

Optional Feature:
- Macro `ACC_FEEDER_OVF_EN`.
- When defined:
  - adds output `r_ovf` (1 bit, reset 0).
  - on each fire in ACCUM, the feeder forms the exact sum in `bit_width`+1 bits: sign-extended `acc_out` ± sign-extended `s_data`. If the exact sum is outside [-2^(`bit_width`-1), 2^(`bit_width`-1)-1], a window-sticky flag is set.
  - a first operand of -2^(`bit_width`-1) with subtract also sets the flag.
  - the flag is copied to `r_ovf` at capture and cleared for the next window.
- When undefined: no `r_ovf` port and no overflow logic.

Test Plan:
- Add 3, add 5, add 7 (`s_last`) back-to-back → `acc_init`=1 on the first only; `r_data`=0x000F, `r_count`=3; `r_valid` high 1 cycle after the last fire.
- Subtract 4 (first), add 10 (`s_last`) → first-cycle `acc_in`=0xFFFC, `acc_sign`=0; `r_data`=0x0006, `r_count`=2.
- Single operand subtract 0x8000 with `s_last` → `r_data`=0x8000, `r_count`=1. With `ACC_FEEDER_OVF_EN` defined, `r_ovf`=1.
- Hold `r_ready`=0 and send windows {1,2} and {5}:
  - first result 0x0003 stays stable.
  - the second window stalls in CAPTURE with `s_ready`=0, and `acc_out` holds 5.
  - raising `r_ready` delivers 0x0003 then 0x0005, in order.
- Assert `rst` after 2 of 4 operands → `r_valid`=0, `r_data`=0, `s_ready`=1. A new window {9 `s_last`} gives `r_data`=0x0009, `r_count`=1.
- With `ACC_FEEDER_OVF_EN` defined, add 0x7FFF then add 1 (`s_last`) → `r_data`=0x8000, `r_ovf`=1. The next window {1 `s_last`} gives `r_ovf`=0.
